// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Select or round-robin arbitration, with optional grant lock for whole packets.
module stream_mux_rr #(
  parameter int NUM_IN   = 9,
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 4,
  parameter int PKT_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_last,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  state_t           state;
  logic [SEL_W-1:0] cur;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] g;
  logic             grant_ok;
  logic             load;
  logic             xfer;

  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    g        = '0;
    grant_ok = 1'b0;
    idx      = 0;
    if (state == LOCK) begin
      g        = cur;
      grant_ok = 1'b1;
    end else if (!mode) begin
      if (int'(sel) < NUM_IN) begin
        g        = sel;
        grant_ok = in_valid[sel];
      end
    end else begin
      // Scan farthest-first so the channel closest after rr_ptr wins last.
      for (int k = NUM_IN; k >= 1; k--) begin
        idx = (int'(rr_ptr) + k) % NUM_IN;
        if (in_valid[SEL_W'(idx)]) begin
          g        = SEL_W'(idx);
          grant_ok = 1'b1;
        end
      end
    end
  end

  assign load = ~out_valid | out_ready;
  assign xfer = grant_ok & load & in_valid[g];

  always_comb begin
    in_ready = '0;
    if (grant_ok) in_ready[g] = load;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
    end else if (xfer && PKT_MODE != 0) begin
      case (state)
        IDLE: if (!in_last[g]) begin
          state <= LOCK;
          cur   <= g;
        end
        LOCK: if (in_last[g]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= LAST_IDX;
    else if (xfer && mode) rr_ptr <= g;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(g)*DATA_W +: DATA_W];
      out_last  <= in_last[g];
      out_chan  <= g;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural reference model.
module tb_stream_mux_rr;

  localparam int NUM_IN   = 9;
  localparam int DATA_W   = 16;
  localparam int SEL_W    = 4;
  localparam int PKT_MODE = 1;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_last;
  logic [NUM_IN-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SEL_W-1:0]         out_chan;
  logic                     out_valid;
  logic                     out_ready;

  stream_mux_rr #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SEL_W(SEL_W), .PKT_MODE(PKT_MODE)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data), .out_last(out_last),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner of the packet lock (-1 = none), last granted channel,
  // and the expected contents of the output register.
  int                m_lock;
  int                m_rr;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  int                m_chan;
  logic [NUM_IN-1:0] obs_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock  = -1;
    m_rr    = NUM_IN - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_chan  = 0;
  endtask

  task automatic idle_inputs();
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, "_data"},  32'(out_data),  32'(m_data));
    check({tag, "_last"},  32'(out_last),  32'(m_last));
    check({tag, "_chan"},  32'(out_chan),  32'(m_chan));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int                g;
    logic              ld;
    logic              xf;
    logic [NUM_IN-1:0] exp_rdy;
    #1;
    g = -1;
    if (m_lock >= 0) g = m_lock;
    else if (!mode) begin
      if (int'(sel) < NUM_IN && in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        int i;
        i = (m_rr + k) % NUM_IN;
        if (in_valid[i]) begin
          g = i;
          break;
        end
      end
    end
    ld      = !m_valid || out_ready;
    exp_rdy = (g >= 0 && ld) ? NUM_IN'(1 << g) : '0;
    xf      = (g >= 0) && ld && in_valid[g];
    obs_rdy = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (xf) begin
      m_valid = 1'b1;
      m_data  = in_data[g*DATA_W +: DATA_W];
      m_last  = in_last[g];
      m_chan  = g;
      if (mode) m_rr = g;
      if (PKT_MODE != 0) begin
        if (m_lock < 0) begin
          if (!in_last[g]) m_lock = g;
        end else if (in_last[g]) m_lock = -1;
      end
    end else if (ld) m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] h_data;
    logic [SEL_W-1:0]  h_chan;
    logic              h_last;
    int                exp_seq [6] = '{0, 4, 8, 0, 4, 8};

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: select mode, channel 3 single beat
    sel = 4'd3;
    in_valid[3] = 1'b1;
    in_last[3]  = 1'b1;
    in_data[3*DATA_W +: DATA_W] = 16'hA5A5;
    step();
    check("t1_data",  32'(out_data),  32'h0000A5A5);
    check("t1_chan",  32'(out_chan),  32'd3);
    check("t1_valid", 32'(out_valid), 32'd1);
    in_valid = '0;
    step();

    // 2: out-of-range select with every channel valid
    sel      = 4'd12;
    in_valid = '1;
    in_last  = '1;
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      check("t2_ready", 32'(obs_rdy),   32'd0);
      check("t2_valid", 32'(out_valid), 32'd0);
    end

    // 3: round-robin over channels 0, 4, 8
    do_reset();
    mode     = 1'b1;
    in_valid = 9'b1_0001_0001;
    in_last  = '1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("t3_chan",  32'(out_chan),  32'(exp_seq[c]));
      check("t3_valid", 32'(out_valid), 32'd1);
    end

    // 4: three-beat packet on channel 2 locks out channel 5
    do_reset();
    mode     = 1'b1;
    in_valid = 9'b0_0010_0100;
    in_last  = 9'b0_0010_0000;
    in_data[5*DATA_W +: DATA_W] = 16'h5555;
    for (int b = 0; b < 3; b++) begin
      in_data[2*DATA_W +: DATA_W] = 16'h2000 + 16'(b);
      in_last[2] = (b == 2);
      step();
      check("t4_rdy5", 32'(obs_rdy[5]), 32'd0);
      check("t4_chan", 32'(out_chan),   32'd2);
    end
    in_valid[2] = 1'b0;
    step();
    check("t4_chan5", 32'(out_chan), 32'd5);

    // 5: four cycles of backpressure hold the output register
    h_data = out_data;
    h_chan = out_chan;
    h_last = out_last;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_data[5*DATA_W +: DATA_W] = 16'h5A00 + 16'(c);
      step();
      check("t5_ready", 32'(obs_rdy),   32'd0);
      check("t5_data",  32'(out_data),  32'(h_data));
      check("t5_chan",  32'(out_chan),  32'(h_chan));
      check("t5_last",  32'(out_last),  32'(h_last));
      check("t5_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("t5_next", 32'(out_data), 32'h5A03);

    // 6: reset in the middle of a channel-1 packet
    do_reset();
    mode     = 1'b1;
    in_valid = 9'b0_0000_0010;
    in_last  = '0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = '1;
    in_last  = '1;
    step();
    check("t6_first_chan", 32'(out_chan), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) mode = 1'($urandom_range(1));
      if ($urandom_range(7) == 0)  sel  = SEL_W'($urandom_range(15));
      for (int i = 0; i < NUM_IN; i++) begin
        in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        in_valid[i] = ($urandom_range(2) != 0);
        in_last[i]  = ($urandom_range(2) == 0);
      end
      out_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
